alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Sequences single ALU operations for the system controller. It accepts a command (function code plus two operands) over a valid/ready handshake and drives the ALU's enable and function inputs. It waits for the ALU result-valid, with a timeout, then serialises the 16-bit result as two bytes (low byte first) to the TX path over a valid/ready handshake. It sits between the command decoder and the ALU / UART TX FIFO.

Parameters:
DATA_WIDTH, 8, operand and TX byte width.
FUN_WIDTH, 4, ALU function code width. Bits [3:2] select the ALU unit class.
TIMEOUT, 15, maximum EXEC cycles to wait for ALU_OUT_VALID. Legal range is 2..255.

Ports:
CLK  in  1  single system clock, rising edge.
RST  in  1  synchronous reset, active-low.
CMD_VALID  in  1  command present.
CMD_READY  out  1  sequencer can accept a command.
CMD_FUN  in  FUN_WIDTH  requested ALU function.
CMD_A  in  DATA_WIDTH  operand A.
CMD_B  in  DATA_WIDTH  operand B.
ALU_EN  out  1  ALU enable.
ALU_FUN  out  FUN_WIDTH  function code to ALU.
ALU_A  out  DATA_WIDTH  operand A to ALU.
ALU_B  out  DATA_WIDTH  operand B to ALU.
ALU_OUT  in  2*DATA_WIDTH  ALU result.
ALU_OUT_VALID  in  1  ALU result valid.
TX_DATA  out  DATA_WIDTH  result byte.
TX_VALID  out  1  TX_DATA valid.
TX_READY  in  1  TX path accepts byte.
BUSY  out  1  high in any state other than IDLE.
ERR  out  1  one-cycle pulse on ALU timeout.

Behaviour:
- Reset is synchronous: RST=0 sampled at a rising CLK edge gives state IDLE at that edge.
- Reset values: CMD_READY=1, ALU_EN=0, ALU_FUN=0, ALU_A=0, ALU_B=0, TX_DATA=0, TX_VALID=0, BUSY=0, ERR=0. The result register and timeout counter also clear.
- Reset mid-operation aborts immediately. No partial byte is completed and no ERR is raised.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, EXEC, SEND_LO, SEND_HI.
- IDLE:
  - CMD_READY=1.
  - On an edge with CMD_VALID=1, CMD_FUN/CMD_A/CMD_B are latched into ALU_FUN/ALU_A/ALU_B.
  - At the same edge: ALU_EN<=1, timeout counter<=0, state->EXEC, CMD_READY<=0.
- EXEC:
  - ALU_EN=1, and ALU_FUN/ALU_A/ALU_B are held stable.
  - On an edge with ALU_OUT_VALID=1: ALU_OUT is captured, ALU_EN<=0, TX_DATA<=ALU_OUT[7:0], TX_VALID<=1, state->SEND_LO.
  - Otherwise the counter increments.
  - After TIMEOUT consecutive EXEC cycles with no valid: ALU_EN<=0, ERR<=1 for exactly one cycle, CMD_READY<=1, state->IDLE. No TX traffic is produced.
  - If valid arrives in the final allowed cycle, valid wins over timeout.
  - ALU_OUT_VALID outside EXEC is ignored.
- SEND_LO:
  - TX_VALID=1. TX_DATA holds the low byte stable until TX_READY=1 is sampled.
  - At that edge: TX_DATA<=captured[15:8], TX_VALID stays 1, state->SEND_HI.
- SEND_HI:
  - Holds until TX_READY=1 is sampled.
  - At that edge: TX_VALID<=0, CMD_READY<=1, state->IDLE.
- Back-pressure: TX_READY low for any number of cycles stalls the FSM. TX_VALID never drops before acceptance and TX_DATA never changes while unaccepted.
- Commands presented while CMD_READY=0 are not consumed. They are accepted only once CMD_READY returns to 1.
- The result is always two bytes, regardless of function class. For 8-bit-class results (logic/compare/shift), the upper byte is whatever the ALU drives.
- Minimum command-to-command time, with the ALU responding 1 cycle after enable and TX_READY tied high: 4 cycles (accept, EXEC, SEND_LO, SEND_HI).

Test Plan:
1. Reset: hold RST=0 for 2 edges with random inputs -> CMD_READY=1 and all other outputs 0. Re-check after RST=1.
2. Add: CMD_FUN=4'h0, A=8'd200, B=8'd100; ALU model returns ALU_OUT=16'd300 with valid 1 cycle after ALU_EN -> ALU_EN high exactly 1 cycle, ALU_FUN=4'h0. TX bytes 8'h2C then 8'h01 on consecutive cycles (TX_READY=1). CMD_READY=1 again 4 cycles after acceptance.
3. Back-pressure: as case 2 with TX_READY=0 for 3 cycles in SEND_LO and 2 in SEND_HI -> TX_VALID stays 1 and TX_DATA stays 8'h2C then 8'h01. Exactly two transfers occur.
4. Busy command: second CMD_VALID with CMD_FUN=4'h4 asserted during EXEC -> not latched (ALU_FUN stays 4'h0). Accepted on the first IDLE cycle afterwards.
5. Timeout: ALU_OUT_VALID held 0, TIMEOUT=15 -> ALU_EN high for 15 cycles, ERR pulse 1 cycle, no TX_VALID, CMD_READY=1. Valid asserted on the 15th cycle instead -> no ERR, normal TX.
6. Reset mid-SEND_HI with TX_READY=0 -> next edge all outputs at reset values. A subsequent command runs normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Purpose : issues one ALU operation per command and streams its 16-bit result out as two bytes, low byte first.
// Latency : accept -> ALU_EN next cycle; first TX byte 1 cycle after ALU_OUT_VALID; 4-cycle command-to-command minimum.
// Backpres: TX_READY low stalls SEND_LO/SEND_HI indefinitely; CMD_READY stays low until the result is fully sent.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-low reset
//   CMD_VALID/READY     command handshake; CMD_FUN/CMD_A/CMD_B latched on acceptance
//   ALU_EN/FUN/A/B      ALU request, held stable for the whole EXEC phase
//   ALU_OUT(_VALID)     ALU result, sampled only in EXEC
//   TX_DATA/VALID/READY result byte stream towards the TX FIFO
//   BUSY                high whenever the sequencer is not idle
//   ERR                 one-cycle pulse when the ALU fails to answer in time
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15   // legal range 2..255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [FUN_WIDTH-1:0]    CMD_FUN,
  input  logic [DATA_WIDTH-1:0]   CMD_A,
  input  logic [DATA_WIDTH-1:0]   CMD_B,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_t;

  // Counter value seen in the last EXEC cycle that is still allowed to
  // receive a result; TIMEOUT EXEC cycles in total (counts 0..TIMEOUT-1).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                  state;
  logic [7:0]              tmo_cnt;
  // Only the upper byte needs keeping: the low byte goes straight to TX_DATA
  // at capture time.
  logic [DATA_WIDTH-1:0]   res_hi;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      res_hi    <= '0;
      CMD_READY <= 1'b1;
      ALU_EN    <= 1'b0;
      ALU_FUN   <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      TX_DATA   <= '0;
      TX_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      // ERR is a pulse: it only survives the cycle in which it is set.
      ERR <= 1'b0;

      unique case (state)
        IDLE: begin
          if (CMD_VALID) begin
            ALU_FUN   <= CMD_FUN;
            ALU_A     <= CMD_A;
            ALU_B     <= CMD_B;
            ALU_EN    <= 1'b1;
            tmo_cnt   <= '0;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            state     <= EXEC;
          end
        end

        EXEC: begin
          // A result in the final allowed cycle takes priority over timeout.
          if (ALU_OUT_VALID) begin
            res_hi   <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
            TX_VALID <= 1'b1;
            ALU_EN   <= 1'b0;
            state    <= SEND_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            ALU_EN    <= 1'b0;
            ERR       <= 1'b1;
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        SEND_LO: begin
          if (TX_READY) begin
            TX_DATA <= res_hi;
            state   <= SEND_HI;
          end
        end

        SEND_HI: begin
          if (TX_READY) begin
            TX_VALID  <= 1'b0;
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
